// File: rtl/acm_pkg.sv
// rtl/acm_pkg.sv - shared encodings for the accumulator scheduler
package acm_pkg;

  localparam logic [1:0] CMD_ACC  = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_CLR  = 2'b10;
  localparam logic [1:0] CMD_READ = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_EXEC  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_arbiter #(
  parameter  int REQ = 4,
  localparam int IW  = $clog2(REQ)
) (
  input  logic [REQ-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [REQ-1:0] grant,
  output logic [IW-1:0]  idx,
  output logic           any
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= REQ) c = c - REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        idx      = IW'(c);
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_scheduler.sv
// rtl/acc_scheduler.sv - shares one external ALU among REQ requesters with private accumulators
module acc_scheduler
  import acm_pkg::*;
#(
  parameter  int N   = 6,
  parameter  int REQ = 4,
  localparam int IW  = $clog2(REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REQ-1:0]   req_valid,
  input  logic [2*REQ-1:0] req_cmd,
  input  logic [3*REQ-1:0] req_op,
  input  logic [N*REQ-1:0] req_data,
  output logic [REQ-1:0]   req_ready,
  output logic [2:0]       alu_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [N-1:0]     alu_y,
  input  logic [2:0]       alu_flags,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IW-1:0]    resp_id,
  output logic [N-1:0]     resp_data,
  output logic [2:0]       resp_flags,
  output logic             busy
);

  state_t          state;
  logic [N-1:0]    acc [REQ];
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [1:0]      cmd_q;
  logic [N-1:0]    data_q;
  logic [REQ-1:0]  arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [1:0]      win_cmd;
  logic [2:0]      win_op;
  logic [N-1:0]    win_data;

  rr_arbiter #(.REQ(REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign win_cmd  = req_cmd[2*win +: 2];
  assign win_op   = req_op[3*win +: 3];
  assign win_data = req_data[N*win +: N];
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      win        <= '0;
      cmd_q      <= CMD_ACC;
      data_q     <= '0;
      req_ready  <= '0;
      alu_op     <= ALU_ADD;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_flags <= '0;
      for (int i = 0; i < REQ; i++) acc[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            win       <= arb_idx;
            req_ready <= arb_grant;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          req_ready <= '0;
          // A winner that withdrew leaves the pointer alone so it re-arbitrates from the same place.
          if (req_valid[win]) begin
            cmd_q  <= win_cmd;
            data_q <= win_data;
            ptr    <= (int'(win) == REQ - 1) ? '0 : win + IW'(1);
            if (win_cmd == CMD_ACC) begin
              alu_op <= win_op;
              alu_a  <= win_data;
              alu_b  <= acc[win];
            end
            state <= ST_EXEC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          resp_valid <= 1'b1;
          resp_id    <= win;
          resp_flags <= '0;
          case (cmd_q)
            CMD_ACC: begin
              acc[win]   <= alu_y;
              resp_data  <= alu_y;
              resp_flags <= alu_flags;
            end
            CMD_LOAD: begin
              acc[win]  <= data_q;
              resp_data <= data_q;
            end
            CMD_CLR: begin
              acc[win]  <= '0;
              resp_data <= '0;
            end
            default: resp_data <= acc[win];
          endcase
          alu_op <= ALU_ADD;
          alu_a  <= '0;
          alu_b  <= '0;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_scheduler.sv
// tb/tb_acc_scheduler.sv - directed table-driven bench for acc_scheduler with a behavioural ALU
module tb_acc_scheduler;
  import acm_pkg::*;

  localparam int N   = 6;
  localparam int REQ = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [REQ-1:0]   req_valid;
  logic [2*REQ-1:0] req_cmd;
  logic [3*REQ-1:0] req_op;
  logic [N*REQ-1:0] req_data;
  logic [REQ-1:0]   req_ready;
  logic [2:0]       alu_op;
  logic [N-1:0]     alu_a, alu_b, alu_y;
  logic [2:0]       alu_flags;
  logic             resp_valid, resp_ready;
  logic [1:0]       resp_id;
  logic [N-1:0]     resp_data;
  logic [2:0]       resp_flags;
  logic             busy;

  acc_scheduler #(.N(N), .REQ(REQ)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd), .req_op(req_op),
    .req_data(req_data), .req_ready(req_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_flags(alu_flags), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_flags(resp_flags), .busy(busy)
  );

  always #5 clock = ~clock;

  // External ALU: y = a op b; carry is the borrow for subtract.
  always_comb begin
    logic [N:0] t;
    case (alu_op)
      ALU_ADD: t = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  t = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  t = {1'b0, alu_a & alu_b};
      default: t = {1'b0, alu_a};
    endcase
    alu_y             = t[N-1:0];
    alu_flags         = '0;
    alu_flags[FLAG_C] = t[N];
    alu_flags[FLAG_Z] = (t[N-1:0] == '0);
    alu_flags[FLAG_N] = t[N-1];
  end

  typedef struct {
    int         id;
    logic [1:0] cmd;
    logic [2:0] op;
    logic [5:0] data;
    logic [5:0] exp_data;
    logic [2:0] exp_flags;
  } vec_t;

  vec_t       vecs[15];
  int         n_vec = 0;
  int         n_fail = 0;
  logic [5:0] model_acc[REQ];
  int         exp_gid[5]   = '{0, 1, 2, 3, 0};
  int         exp_rdata[5] = '{1, 2, 3, 4, 2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [REQ-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < REQ; i++) model_acc[i] = '0;
  endtask

  task automatic start_txn(input int id, input logic [1:0] cmd, input logic [2:0] op,
                           input logic [5:0] data, output bit ok);
    ok = 1'b0;
    req_cmd[2*id +: 2]  = cmd;
    req_op[3*id +: 3]   = op;
    req_data[N*id +: N] = data;
    req_valid[id]       = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL grant_timeout id%0d: req_ready=%b expected bit %0d", id, req_ready, id);
      req_valid[id] = 1'b0;
      return;
    end
    check("grant_onehot", req_ready, 32'(1) << id);
    @(negedge clock);
    req_valid[id] = 1'b0;
  endtask

  task automatic finish_txn(input int id, input logic [1:0] cmd, input logic [2:0] op,
                            input logic [5:0] data, input logic [5:0] exp_data, input logic [2:0] exp_flags);
    logic is_acc;
    is_acc = (cmd == CMD_ACC);
    check("exec_alu_op", alu_op, is_acc ? op : 3'b000);
    check("exec_alu_a", alu_a, is_acc ? data : 6'd0);
    check("exec_alu_b", alu_b, is_acc ? model_acc[id] : 6'd0);
    check("exec_resp_valid", resp_valid, 0);
    @(negedge clock);
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, id);
    check("resp_data", resp_data, exp_data);
    check("resp_flags", resp_flags, exp_flags);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check("resp_dropped", resp_valid, 0);
    if (cmd != CMD_READ) model_acc[id] = exp_data;
  endtask

  task automatic do_txn(input int id, input logic [1:0] cmd, input logic [2:0] op,
                        input logic [5:0] data, input logic [5:0] exp_data, input logic [2:0] exp_flags);
    bit ok;
    start_txn(id, cmd, op, data, ok);
    if (ok) finish_txn(id, cmd, op, data, exp_data, exp_flags);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, nr;
    int g_id[5], g_cyc[5], r_id[5], r_data[5];
    bit ok;

    vecs[0]  = '{0, CMD_LOAD, ALU_ADD, 6'd5,  6'd5,  3'b000};
    vecs[1]  = '{0, CMD_ACC,  ALU_ADD, 6'd3,  6'd8,  3'b000};
    vecs[2]  = '{1, CMD_LOAD, ALU_ADD, 6'd60, 6'd60, 3'b000};
    vecs[3]  = '{1, CMD_ACC,  ALU_ADD, 6'd10, 6'd6,  3'b001};
    vecs[4]  = '{0, CMD_READ, ALU_ADD, 6'd0,  6'd8,  3'b000};
    vecs[5]  = '{0, CMD_CLR,  ALU_ADD, 6'd0,  6'd0,  3'b000};
    vecs[6]  = '{0, CMD_ACC,  ALU_ADD, 6'd0,  6'd0,  3'b010};
    vecs[7]  = '{2, CMD_LOAD, ALU_ADD, 6'd33, 6'd33, 3'b000};
    vecs[8]  = '{2, CMD_ACC,  ALU_ADD, 6'd0,  6'd33, 3'b100};
    vecs[9]  = '{2, CMD_ACC,  3'b010,  6'd1,  6'd1,  3'b000};
    vecs[10] = '{3, CMD_LOAD, ALU_ADD, 6'd63, 6'd63, 3'b000};
    vecs[11] = '{3, CMD_ACC,  ALU_ADD, 6'd1,  6'd0,  3'b011};
    vecs[12] = '{1, CMD_READ, ALU_ADD, 6'd0,  6'd6,  3'b000};
    vecs[13] = '{3, CMD_ACC,  3'b001,  6'd5,  6'd5,  3'b000};
    vecs[14] = '{3, CMD_ACC,  3'b001,  6'd2,  6'd61, 3'b101};

    req_valid = '0; req_cmd = '0; req_op = '0; req_data = '0; resp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_flags", resp_flags, 0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 0);
    do_reset();

    foreach (vecs[i])
      do_txn(vecs[i].id, vecs[i].cmd, vecs[i].op, vecs[i].data, vecs[i].exp_data, vecs[i].exp_flags);

    // All four requesters held valid from a fresh pointer.
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < REQ; i++) begin
      req_cmd[2*i +: 2]  = CMD_ACC;
      req_op[3*i +: 3]   = ALU_ADD;
      req_data[N*i +: N] = 6'(i + 1);
    end
    req_valid = '1;
    ng = 0; nr = 0;
    for (int c = 0; c < 60 && nr < 5; c++) begin
      @(negedge clock);
      if (req_ready != '0 && ng < 5) begin g_id[ng] = oh2i(req_ready); g_cyc[ng] = c; ng++; end
      if (resp_valid && nr < 5) begin
        r_id[nr] = resp_id; r_data[nr] = resp_data; nr++;
        if (nr == 5) req_valid = '0;
      end
    end
    @(negedge clock);
    resp_ready = 1'b0;
    check("rr_grant_count", ng, 5);
    check("rr_resp_count", nr, 5);
    for (int k = 0; k < ng; k++) check("rr_grant_order", g_id[k], exp_gid[k]);
    for (int k = 1; k < ng; k++) check("rr_spacing", g_cyc[k] - g_cyc[k-1], 4);
    for (int k = 0; k < nr; k++) begin
      check("rr_resp_id", r_id[k], exp_gid[k]);
      check("rr_resp_data", r_data[k], exp_rdata[k]);
    end
    model_acc[0] = 6'd2; model_acc[1] = 6'd2; model_acc[2] = 6'd3; model_acc[3] = 6'd4;

    // Back-pressure: response held while another requester waits.
    req_cmd[2*2 +: 2] = CMD_READ;
    req_valid[2] = 1'b1;
    start_txn(1, CMD_LOAD, ALU_ADD, 6'd7, ok);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_id", resp_id, 1);
      check("bp_resp_data", resp_data, 7);
      check("bp_busy", busy, 1);
      check("bp_req_ready", req_ready, 0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    req_valid[2] = 1'b0;
    @(negedge clock);
    resp_ready = 1'b0;
    check("bp_released", resp_valid, 0);
    model_acc[1] = 6'd7;

    // Reset in the middle of an ACC for requester 2.
    do_txn(2, CMD_LOAD, ALU_ADD, 6'd9, 6'd9, 3'b000);
    start_txn(2, CMD_ACC, ALU_ADD, 6'd4, ok);
    check("mid_exec_alu_b", alu_b, 9);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_resp_data", resp_data, 0);
    repeat (3) begin
      @(negedge clock);
      check("abort_no_resp", resp_valid, 0);
    end
    for (int i = 0; i < REQ; i++) model_acc[i] = '0;
    do_txn(2, CMD_READ, ALU_ADD, 6'd0, 6'd0, 3'b000);

    // Requester 3 withdraws in its grant cycle; pointer stays at 3.
    req_cmd[2*3 +: 2] = CMD_READ;
    req_valid[3] = 1'b1;
    @(negedge clock);
    check("drop_grant", req_ready, 4'b1000);
    req_valid[3] = 1'b0;
    @(negedge clock);
    check("drop_idle", busy, 0);
    check("drop_ready_clear", req_ready, 0);
    repeat (4) begin
      @(negedge clock);
      check("drop_no_resp", resp_valid, 0);
    end
    req_cmd[2*0 +: 2] = CMD_READ;
    req_valid = 4'b1001;
    @(negedge clock);
    check("drop_ptr_kept", req_ready, 4'b1000);
    @(negedge clock);
    req_valid = '0;
    finish_txn(3, CMD_READ, ALU_ADD, 6'd0, 6'd0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
